alu_controller: RTL and testbench
=================================

ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 Parameter DATA_W, 16, operand/result width; matches ALU A/B/Q width.
REQ-002 Parameter NREGS, 8, register-file depth; address width 3.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 In_Valid  input  1  instruction request valid.
REQ-006 In_Instr  input  12  {op[11:9], dst[8:6], srca[5:3], srcb[2:0]}.
REQ-007 In_Ready  output  1  controller can accept an instruction this cycle.
REQ-008 Ld_En  input  1  direct register load strobe.
REQ-009 Ld_Addr  input  3  load target register.
REQ-010 Ld_Data  input  DATA_W  load value.
REQ-011 Rd_Addr  input  3  debug read address.
REQ-012 Rd_Data  output  DATA_W  combinational contents of register Rd_Addr.
REQ-013 Alu_Sel  output  3  registered function select to downstream ALU.
REQ-014 Alu_A, Alu_B  output  DATA_W each  registered operands to ALU.
REQ-015 Alu_Q  input  DATA_W  combinational ALU result.
REQ-016 Done  output  1  one-cycle pulse: result being written this cycle.
REQ-017 Zero  output  1  registered flag: last written result equal to 0.

Function
REQ-018 FSM states IDLE, READ, EXEC, WRITE; transitions IDLE->READ on accept, READ->EXEC, EXEC->WRITE, WRITE->IDLE unconditionally.
REQ-019 In_Ready = (state==IDLE) & ~Ld_En, combinational; accept = In_Valid & In_Ready, instruction latched at that edge.
REQ-020 In_Valid while not ready is ignored; requester holds In_Instr stable until accepted.
REQ-021 READ: at its ending edge Alu_Sel<=op, Alu_A<=reg[srca], Alu_B<=reg[srcb]; values held until the next READ.
REQ-022 EXEC: at its ending edge Alu_Q captured into internal result register.
REQ-023 WRITE: Done=1 (Moore); at its ending edge reg[dst]<=result, Zero<=(result==0).
REQ-024 Latency: accept at edge N -> Done high in cycle after edge N+2 -> register written at edge N+3; throughput one instruction per 4 cycles; In_Ready may be high in the cycle after WRITE.
REQ-025 Ld_En honoured only in IDLE: reg[Ld_Addr]<=Ld_Data at the edge; Ld_En outside IDLE ignored; Ld_En and In_Valid in same IDLE cycle -> load wins, no accept.
REQ-026 Operand reads see all prior writes; srca==srcb==dst legal (read-before-write, no hazard since ops serialised).
REQ-027 All arithmetic is DATA_W wide, wraps modulo 2^DATA_W; no carry/overflow outputs; opcode semantics owned by ALU (0 zero, 1 add, 2 sub, 3 pass A, 4 xor, 5 or, 6 and, 7 inc A).
REQ-028 Rd_Data reflects a write from the cycle after the write edge.

Reset
REQ-029 Reset asserted: state=IDLE, all registers=0, Alu_Sel=0, Alu_A=Alu_B=0, result=0, Zero=0, Done=0, immediately and independent of Clk.
REQ-030 Reset mid-operation abandons the instruction; no register write, no Done pulse.
REQ-031 After deassertion In_Ready=1 in the first cycle (if Ld_En low).

Structure
REQ-032 Shared package alu_pkg holds the 8 opcode constants, FSM state encoding, and In_Instr field positions; ALU and this block both use it.
REQ-033 One sub-module reg_file: NREGS x DATA_W, 1 synchronous write port, 3 combinational read ports (srca, srcb, Rd_Addr), async reset to 0.

Verification
REQ-034 Load r1=0x0005, r2=0x0003; instr op=1 dst=3 a=1 b=2 -> Alu_A=5, Alu_B=3, Done 3 cycles after accept, r3=0x0008, Zero=0.
REQ-035 r1=0x0003, r2=0x0003, op=2 dst=4 -> r4=0x0000, Zero=1; op=7 on r5=0xFFFF -> 0x0000 wrap, Zero=1.
REQ-036 In_Valid held high continuously with 3 instrs -> In_Ready high only in IDLE cycles, accepts spaced exactly 4 cycles, each instruction executed once.
REQ-037 Ld_En and In_Valid same IDLE cycle -> load performed, In_Ready=0, instruction accepted next cycle; Ld_En during EXEC -> no register change.
REQ-038 Reset asserted in EXEC -> outputs 0 without clock edge, dst unchanged from reset value, no Done.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, controller FSM encoding, instruction field layout.
// Latency: none (types and constants only).
// Backpressure: none.
package alu_pkg;

    // Instruction word layout: {op[11:9], dst[8:6], srca[5:3], srcb[2:0]}
    localparam int INSTR_W  = 12;
    localparam int REG_AW   = 3;
    localparam int OP_LSB   = 9;
    localparam int DST_LSB  = 6;
    localparam int SRCA_LSB = 3;
    localparam int SRCB_LSB = 0;

    typedef logic [2:0]        op_t;
    typedef logic [REG_AW-1:0] raddr_t;

    // Opcode semantics are implemented by the downstream ALU
    localparam op_t OP_ZERO = 3'd0;
    localparam op_t OP_ADD  = 3'd1;
    localparam op_t OP_SUB  = 3'd2;
    localparam op_t OP_PASS = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_OR   = 3'd5;
    localparam op_t OP_AND  = 3'd6;
    localparam op_t OP_INC  = 3'd7;

    typedef struct packed {
        op_t    op;
        raddr_t dst;
        raddr_t srca;
        raddr_t srcb;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Split a raw instruction word into its fields
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op   = raw[OP_LSB   +: 3];
        d.dst  = raw[DST_LSB  +: REG_AW];
        d.srca = raw[SRCA_LSB +: REG_AW];
        d.srcb = raw[SRCB_LSB +: REG_AW];
        return d;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: NREGS x DATA_W, one synchronous write port, three combinational read ports.
// Latency: write visible on read ports the cycle after the write edge; reads are combinational.
// Backpressure: none; a write is taken on every edge where we is high.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage: cleared on reset, single write port otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_controller.sv
// Sequencer for an external ALU: reads two registers, issues them to the ALU, writes the result back.
// Latency: accept at edge N -> done in the cycle after edge N+2 -> register written at edge N+3.
// Backpressure: in_ready only in IDLE with no direct load pending; one instruction per 4 cycles.
module alu_controller
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               ld_en,
    input  logic [REG_AW-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic [REG_AW-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic [2:0]         alu_sel,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_q,
    output logic               done,
    output logic               zero
);

    state_t            state;
    state_t            state_nxt;
    instr_t            instr_q;
    logic [DATA_W-1:0] result_q;
    logic              accept;

    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    assign accept = in_valid & in_ready;

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (REG_AW)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .ra_addr (instr_q.srca),
        .ra_data (src_a),
        .rb_addr (instr_q.srcb),
        .rb_data (src_b),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and write-port steering; a direct load in IDLE
    // takes the write port and blocks acceptance for that cycle
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = ld_addr;
        wr_data   = ld_data;
        case (state)
            ST_IDLE: begin
                in_ready = ~ld_en;
                if (ld_en) begin
                    wr_en = 1'b1;
                end else if (in_valid) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                done      = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = instr_q.dst;
                wr_data   = result_q;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the instruction at the accepting edge; it stays put until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
        end else if (accept) begin
            instr_q <= decode_instr(in_instr);
        end
    end

    // Issue opcode and operands to the ALU at the end of READ; held until the next READ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_sel <= OP_ZERO;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (state == ST_READ) begin
            alu_sel <= instr_q.op;
            alu_a   <= src_a;
            alu_b   <= src_b;
        end
    end

    // Capture the ALU result at the end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if (state == ST_EXEC) begin
            result_q <= alu_q;
        end
    end

    // Zero flag tracks the value committed to the register file at the end of WRITE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero <= 1'b0;
        end else if (state == ST_WRITE) begin
            zero <= (result_q == '0);
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
module tb_alu_controller;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [11:0]       in_instr = '0;
    logic              in_ready;
    logic              ld_en = 1'b0;
    logic [2:0]        ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [2:0]        rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_q;
    logic              done;
    logic              zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: register contents after every completed instruction/load
    logic [DATA_W-1:0] mregs [8];

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            3'd0: return '0;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a;
            3'd4: return a ^ b;
            3'd5: return a | b;
            3'd6: return a & b;
            default: return a + 1'b1;
        endcase
    endfunction

    // Downstream ALU stand-in
    always_comb alu_q = ref_alu(alu_sel, alu_a, alu_b);

    alu_controller #(.DATA_W(DATA_W), .NREGS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .alu_sel  (alu_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_q    (alu_q),
        .done     (done),
        .zero     (zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [2:0] addr, input logic [DATA_W-1:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en = 1'b0;
        mregs[addr] = data;
    endtask

    // Runs one instruction from IDLE and checks every cycle of its life
    task automatic exec_instr(input logic [2:0] op, input logic [2:0] dst,
                              input logic [2:0] a, input logic [2:0] b);
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] old;
        exp = ref_alu(op, mregs[a], mregs[b]);
        old = mregs[dst];
        rd_addr  = dst;
        in_instr = {op, dst, a, b};
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL exec_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_instr = 12'($urandom);
        @(negedge clk);
        n_checks++;
        if ({done, in_ready} !== 2'b00) begin
            n_fail++; $display("FAIL exec_read: done,in_ready=%b want 00", {done, in_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({alu_sel, alu_a, alu_b, done} !== {op, mregs[a], mregs[b], 1'b0}) begin
            n_fail++; $display("FAIL exec_operands: sel=%0d a=%h b=%h done=%b want sel=%0d a=%h b=%h done=0",
                               alu_sel, alu_a, alu_b, done, op, mregs[a], mregs[b]);
        end
        @(negedge clk);
        n_checks++;
        if ({done, rd_data} !== {1'b1, old}) begin
            n_fail++; $display("FAIL exec_write: done=%b r%0d=%h want done=1 r=%h", done, dst, rd_data, old);
        end
        @(negedge clk);
        n_checks++;
        if ({done, in_ready, zero, rd_data} !== {1'b0, 1'b1, (exp == '0), exp}) begin
            n_fail++; $display("FAIL exec_result: done=%b rdy=%b zero=%b r%0d=%h want 0 1 %b %h",
                               done, in_ready, zero, dst, rd_data, (exp == '0), exp);
        end
        mregs[dst] = exp;
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({alu_sel, alu_a, alu_b, done, zero, in_ready} !== {3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_outputs: sel=%0d a=%h b=%h done=%b zero=%b rdy=%b", alu_sel, alu_a, alu_b, done, zero, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #0.5;
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++; $display("FAIL reset_regs: r%0d=%h want 0000", i, rd_data);
            end
            mregs[i] = '0;
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_add();
        load_reg(3'd1, 16'h0005);
        load_reg(3'd2, 16'h0003);
        exec_instr(3'd1, 3'd3, 3'd1, 3'd2);
        rd_addr = 3'd3;
        #1;
        n_checks++;
        if ({rd_data, zero} !== {16'h0008, 1'b0}) begin
            n_fail++; $display("FAIL add_const: r3=%h zero=%b want 0008 0", rd_data, zero);
        end
    endtask

    task automatic test_wrap();
        load_reg(3'd1, 16'h0003);
        load_reg(3'd2, 16'h0003);
        exec_instr(3'd2, 3'd4, 3'd1, 3'd2);
        rd_addr = 3'd4;
        #1;
        n_checks++;
        if ({rd_data, zero} !== {16'h0000, 1'b1}) begin
            n_fail++; $display("FAIL sub_zero: r4=%h zero=%b want 0000 1", rd_data, zero);
        end
        load_reg(3'd5, 16'hFFFF);
        exec_instr(3'd7, 3'd6, 3'd5, 3'd0);
        rd_addr = 3'd6;
        #1;
        n_checks++;
        if ({rd_data, zero} !== {16'h0000, 1'b1}) begin
            n_fail++; $display("FAIL inc_wrap: r6=%h zero=%b want 0000 1", rd_data, zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] prog [3];
        int k;
        int done_cnt;
        logic [2:0] d;
        d = 3'($urandom);
        prog[0] = {3'd7, d, d, 3'($urandom)};
        prog[1] = {3'd1, 3'($urandom), 3'($urandom), 3'($urandom)};
        prog[2] = {3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)};
        for (int i = 0; i < 3; i++) begin
            mregs[prog[i][8:6]] = ref_alu(prog[i][11:9], mregs[prog[i][5:3]], mregs[prog[i][2:0]]);
        end
        k = 0;
        done_cnt = 0;
        in_valid = 1'b1;
        in_instr = prog[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== (cyc % 4 == 0)) begin
                n_fail++; $display("FAIL b2b_ready: cycle %0d in_ready=%b want %b", cyc, in_ready, (cyc % 4 == 0));
            end
            if (done === 1'b1) done_cnt++;
            tick();
            if (cyc % 4 == 0) begin
                k++;
                if (k < 3) in_instr = prog[k];
                else in_valid = 1'b0;
            end
        end
        n_checks++;
        if (done_cnt !== 3) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #0.5;
            n_checks++;
            if (rd_data !== mregs[i]) begin
                n_fail++; $display("FAIL b2b_regs: r%0d=%h want %h", i, rd_data, mregs[i]);
            end
        end
        tick();
    endtask

    task automatic test_load_priority();
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] old7;
        data = 16'($urandom) | 16'h0100;
        in_valid = 1'b1;
        in_instr = {3'd3, 3'd7, 3'd6, 3'd0};
        ld_en    = 1'b1;
        ld_addr  = 3'd6;
        ld_data  = data;
        rd_addr  = 3'd6;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL ld_prio_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        ld_en = 1'b0;
        mregs[6] = data;
        @(negedge clk);
        n_checks++;
        if ({in_ready, rd_data} !== {1'b1, data}) begin
            n_fail++; $display("FAIL ld_prio_load: rdy=%b r6=%h want 1 %h", in_ready, rd_data, data);
        end
        tick();
        in_valid = 1'b0;
        tick();
        old7    = mregs[7];
        ld_en   = 1'b1;
        ld_addr = 3'd7;
        ld_data = ~data;
        rd_addr = 3'd7;
        @(negedge clk);
        n_checks++;
        if ({alu_sel, alu_a, in_ready} !== {3'd3, data, 1'b0}) begin
            n_fail++; $display("FAIL ld_exec_issue: sel=%0d a=%h rdy=%b want 3 %h 0", alu_sel, alu_a, in_ready, data);
        end
        tick();
        ld_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, rd_data} !== {1'b1, old7}) begin
            n_fail++; $display("FAIL ld_exec_ignored: done=%b r7=%h want 1 %h", done, rd_data, old7);
        end
        tick();
        mregs[7] = data;
        n_checks++;
        if (rd_data !== data) begin
            n_fail++; $display("FAIL ld_exec_result: r7=%h want %h", rd_data, data);
        end
    endtask

    task automatic test_reset_mid();
        load_reg(3'd2, 16'($urandom) | 16'h0001);
        rd_addr  = 3'd5;
        in_instr = {3'd7, 3'd5, 3'd2, 3'd2};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({alu_sel, alu_a, alu_b, done, zero, in_ready, rd_data} !== {3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0}) begin
            n_fail++; $display("FAIL reset_mid_async: sel=%0d a=%h b=%h done=%b zero=%b rdy=%b r5=%h",
                               alu_sel, alu_a, alu_b, done, zero, in_ready, rd_data);
        end
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({done, alu_a} !== {1'b0, 16'd0}) begin
                n_fail++; $display("FAIL reset_mid_hold: done=%b a=%h want 0 0000", done, alu_a);
            end
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, done, rd_data} !== {1'b1, 1'b0, 16'd0}) begin
            n_fail++; $display("FAIL reset_mid_release: rdy=%b done=%b r5=%h want 1 0 0000", in_ready, done, rd_data);
        end
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if ({done, rd_data} !== {1'b0, 16'd0}) begin
                n_fail++; $display("FAIL reset_mid_no_write: done=%b r5=%h want 0 0000", done, rd_data);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_reg(3'($urandom), 16'($urandom));
            end
            exec_instr(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #0.5;
            n_checks++;
            if (rd_data !== mregs[i]) begin
                n_fail++; $display("FAIL random_regs: r%0d=%h want %h", i, rd_data, mregs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_back_to_back();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
